// File: rtl/cla_pkg.sv
// Shared definitions for the 4-bit carry-lookahead adder: width, per-bit P/G helper,
// and the registered result bundle.
package cla_pkg;

  localparam int unsigned CLA_W = 4;

  typedef struct packed {
    logic [CLA_W-1:0] s;
    logic             cout;
    logic             gp;
    logic             gg;
  } cla_res_t;

  // Returns {propagate, generate} for one bit position.
  function automatic logic [1:0] cla_pg(input logic a, input logic b);
    return {a ^ b, a & b};
  endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// Combinational 4-bit lookahead unit: flattened sum-of-products carries plus group P/G.
// Usable unchanged as the second-level unit when cascading 4-bit groups.
module cla_lookahead4
  import cla_pkg::*;
(
  input  logic [CLA_W-1:0] p,
  input  logic [CLA_W-1:0] g,
  input  logic             cin,
  output logic [CLA_W:1]   c,
  output logic             P,
  output logic             G
);

  // gen_pre[i]: carry out of bit i generated inside bits [i:0], independent of cin.
  logic [CLA_W-1:0] gen_pre;

  for (genvar i = 0; i < CLA_W; i++) begin : gen_carry
    logic [i:0] term;
    for (genvar j = 0; j <= i; j++) begin : gen_term
      if (j == i) begin : gen_top
        assign term[j] = g[j];
      end else begin : gen_chain
        assign term[j] = g[j] & (&p[i:j+1]);
      end
    end
    assign gen_pre[i] = |term;
    assign c[i+1]     = gen_pre[i] | (cin & (&p[i:0]));
  end

  assign P = &p;
  assign G = gen_pre[CLA_W-1];

endmodule

// File: rtl/cla_add4_gen.sv
// Registered 4-bit carry-lookahead adder with group propagate/generate outputs;
// one-cycle latency, synchronous active-high reset.
module cla_add4_gen
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cIn,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  output logic             gP,
  output logic             gG
);

  if (WIDTH != CLA_W) begin : gen_bad_width
    $error("cla_add4_gen: only WIDTH=4 is supported");
  end

  logic [CLA_W-1:0] p, g;
  logic [CLA_W:1]   c;
  logic [CLA_W-1:0] cvec;
  logic             grp_p, grp_g;
  cla_res_t         res_d, res_q;

  for (genvar i = 0; i < CLA_W; i++) begin : gen_pg
    assign {p[i], g[i]} = cla_pg(x[i], y[i]);
  end

  cla_lookahead4 u_lookahead (
    .p   (p),
    .g   (g),
    .cin (cIn),
    .c   (c),
    .P   (grp_p),
    .G   (grp_g)
  );

  // Carry into each bit position: cIn for bit 0, lookahead carries above.
  assign cvec = {c[CLA_W-1:1], cIn};

  always_comb begin
    res_d      = '0;
    res_d.s    = p ^ cvec;
    res_d.cout = c[CLA_W];
    res_d.gp   = grp_p;
    res_d.gg   = grp_g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign s    = res_q.s;
  assign cOut = res_q.cout;
  assign gP   = res_q.gp;
  assign gG   = res_q.gg;

endmodule

// File: tb/tb_cla_add4_gen.sv
// Self-checking bench for cla_add4_gen: directed cases, exhaustive sweep and random
// stream compared against an arithmetic reference model.
module tb_cla_add4_gen;

  logic       clk;
  logic       rst;
  logic [3:0] x, y;
  logic       cIn;
  logic [3:0] s;
  logic       cOut, gP, gG;

  int unsigned n_cmp;
  int unsigned n_bad;

  cla_add4_gen #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .cIn  (cIn),
    .s    (s),
    .cOut (cOut),
    .gP   (gP),
    .gG   (gG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one operand set for one edge, then check the registered result against the model.
  task automatic step(input string tag, input logic r, input logic [3:0] a,
                      input logic [3:0] b, input logic ci);
    int unsigned total;
    logic [3:0]  e_s;
    logic        e_c, e_p, e_g;
    rst = r;
    x   = a;
    y   = b;
    cIn = ci;
    @(posedge clk);
    #1;
    total = int'(a) + int'(b) + int'(ci);
    if (r) begin
      e_s = 4'h0; e_c = 1'b0; e_p = 1'b0; e_g = 1'b0;
    end else begin
      e_s = total[3:0];
      e_c = (total >= 16);
      e_p = ((a ^ b) == 4'hF);
      e_g = ((int'(a) + int'(b)) >= 16);
    end
    check_eq({tag, ".s"},    {28'h0, s},     {28'h0, e_s});
    check_eq({tag, ".cOut"}, {31'h0, cOut},  {31'h0, e_c});
    check_eq({tag, ".gP"},   {31'h0, gP},    {31'h0, e_p});
    check_eq({tag, ".gG"},   {31'h0, gG},    {31'h0, e_g});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    x   = 4'hF;
    y   = 4'hF;
    cIn = 1'b1;

    step("rst0", 1'b1, 4'hF, 4'hF, 1'b1);
    step("rst1", 1'b1, 4'hF, 4'hF, 1'b1);

    step("a_plus_1",  1'b0, 4'hA, 4'h1, 1'b0);
    step("f_0_c1",    1'b0, 4'hF, 4'h0, 1'b1);
    step("8_8",       1'b0, 4'h8, 4'h8, 1'b0);

    step("bb0", 1'b0, 4'h3, 4'h4, 1'b0);
    step("bb1", 1'b0, 4'h7, 4'h9, 1'b1);
    step("bb2", 1'b0, 4'hF, 4'hF, 1'b1);

    step("midrst", 1'b1, 4'h9, 4'h9, 1'b0);
    step("zero",   1'b0, 4'h0, 4'h0, 1'b0);

    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      v = k[8:0];
      step("sweep", 1'b0, v[3:0], v[7:4], v[8]);
    end

    for (int k = 0; k < 300; k++) begin
      logic r;
      r = ($urandom_range(0, 15) == 0);
      step("rand", r, 4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
